commit_trace_monitor: RTL and testbench
=======================================

COMMIT_TRACE_MONITOR -- requirements
Module: commit_trace_monitor

Interface
REQ-001 SHALL have parameter NCH, default 2, number of commit channels retired per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 16, trace FIFO entries (power of two, >= NCH).
REQ-003 SHALL have parameter TIMEOUT, default 100000000, stall limit in cycles without a commit.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port commit_valid  input  NCH  per-channel retire strobe.
REQ-007 SHALL have port commit_pc / commit_pc_next / commit_insn  input  NCH*32 each  per-channel pc_rdata, pc_wdata, instruction.
REQ-008 SHALL have port commit_regf_we  input  NCH, commit_rd_addr  input  NCH*5, commit_rd_wdata  input  NCH*32  register writeback.
REQ-009 SHALL have ports mem_read, mem_write  input  1 each  memory interface strobes.
REQ-010 SHALL have port trace_valid  output  1, trace_ready  input  1  trace drain handshake.
REQ-011 SHALL have port trace_order  output  64, trace_pc  output  32, trace_insn  output  32, trace_rd_addr  output  5, trace_rd_wdata  output  32  head record.
REQ-012 SHALL have ports halt, timeout, overflow, rw_conflict  output  1 each  sticky status flags.
REQ-013 SHALL have port commit_count  output  64  total accepted commits.

Function
REQ-014 Valid channels in a cycle SHALL be ordered by ascending channel index; invalid channels skipped (compacted).
REQ-015 Each valid channel SHALL receive order = order_ctr + its rank among valid channels; order_ctr SHALL advance by popcount(commit_valid) every cycle, accepted or not.
REQ-016 Record rd_addr/rd_wdata SHALL be zero when regf_we is 0 or rd_addr is 0.
REQ-017 FIFO SHALL enqueue all valid records of a cycle iff free entries (counted before the same-cycle dequeue) >= popcount; otherwise none enqueued, overflow set.
REQ-018 Records SHALL be written to consecutive slots; pointers wrap modulo DEPTH.
REQ-019 trace_valid SHALL equal FIFO non-empty; trace_* SHALL present head entry combinationally from storage; dequeue on trace_valid & trace_ready.
REQ-020 Enqueue latency SHALL be one cycle: record committed at edge N visible at trace_* after edge N when FIFO was empty.
REQ-021 Simultaneous enqueue and dequeue SHALL both occur; occupancy changes by (accepted - 1).
REQ-022 commit_count SHALL advance only by accepted records.
REQ-023 halt SHALL set when any accepted channel has commit_pc_next == commit_pc; that record is enqueued; subsequent commits SHALL be ignored (no enqueue, no order advance).
REQ-024 Stall counter SHALL clear on any cycle with commit_valid != 0, else increment; timeout SHALL set when counter reaches TIMEOUT-1 and the counter SHALL saturate.
REQ-025 Stall counter SHALL hold once halt is set.
REQ-026 Sticky flags SHALL clear only on reset; FIFO SHALL continue draining after halt/timeout/overflow.

Reset
REQ-027 On rst assertion, SHALL immediately clear FIFO pointers and occupancy, order_ctr, commit_count, stall counter and all flags; trace_valid 0, trace_* data 0.
REQ-028 Reset mid-drain SHALL discard all buffered records; FIFO storage need not be cleared.
REQ-029 No record SHALL be accepted on the first edge with rst asserted.

Configuration
REQ-030 With COMMIT_MON_RW_CHECK_EN defined, rw_conflict SHALL set on any edge where mem_read & mem_write, independent of halt.
REQ-031 Without COMMIT_MON_RW_CHECK_EN, rw_conflict SHALL be constant 0 and mem_read/mem_write unused.

Verification
REQ-032 NCH=2: commit_valid=2'b11, pc 0x60000000/0x60000004, trace_ready=1 -> orders 0,1 drained in successive cycles, commit_count=2.
REQ-033 commit_valid=2'b10 then 2'b01 -> orders 0 then 1 both reported as channel-compacted records; rd_addr=0 records show rd_wdata 0.
REQ-034 DEPTH=4, trace_ready=0, three cycles of 2'b11 -> first two cycles accepted (count 4), third dropped, overflow=1, next accepted order = 6.
REQ-035 Channel 1 commits pc=pc_next=0x60000100 -> halt=1 that edge, record enqueued, later commits ignored, commit_count frozen.
REQ-036 TIMEOUT=8, no commits after reset -> timeout=1 on 8th edge after reset release; a commit earlier restarts count.
REQ-037 With COMMIT_MON_RW_CHECK_EN, mem_read=mem_write=1 one cycle -> rw_conflict=1 until rst; without macro -> stays 0.

Source files
------------

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: collects up to NCH retired instructions per cycle into an
//    ordered trace FIFO and watches for halt, commit stalls, FIFO overflow and
//    memory read/write strobe conflicts.
// Latency: a record accepted at edge N is on trace_* after edge N (1 cycle).
// Backpressure: trace_valid/trace_ready drain. A cycle's commits are accepted
//    all-or-nothing against free space counted before the same-cycle dequeue.
//    When they do not fit they are dropped and overflow is raised.
// Optional feature macro: COMMIT_MON_RW_CHECK_EN (enables rw_conflict detection).
//
// Ports:
//    clk, rst                    clock, asynchronous active-high reset
//    commit_*                    per-channel retire bus (NCH lanes, lane 0 oldest)
//    mem_read, mem_write         memory strobes, checked only with the macro
//    trace_valid/trace_ready     head-of-FIFO handshake
//    trace_order .. rd_wdata     head record; zero while the FIFO is empty
//    halt, timeout, overflow,
//    rw_conflict                 sticky status flags, cleared only by rst
//    commit_count                total records accepted into the FIFO
module commit_trace_monitor #(
   parameter int NCH     = 2,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 100000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    commit_valid,
   input  logic [NCH*32-1:0] commit_pc,
   input  logic [NCH*32-1:0] commit_pc_next,
   input  logic [NCH*32-1:0] commit_insn,
   input  logic [NCH-1:0]    commit_regf_we,
   input  logic [NCH*5-1:0]  commit_rd_addr,
   input  logic [NCH*32-1:0] commit_rd_wdata,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic              trace_valid,
   input  logic              trace_ready,
   output logic [63:0]       trace_order,
   output logic [31:0]       trace_pc,
   output logic [31:0]       trace_insn,
   output logic [4:0]        trace_rd_addr,
   output logic [31:0]       trace_rd_wdata,
   output logic              halt,
   output logic              timeout,
   output logic              overflow,
   output logic              rw_conflict,
   output logic [63:0]       commit_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // DEPTH is a power of two, so masking implements the modulo-DEPTH wrap.
   localparam logic [31:0]   PTR_MASK    = 32'(DEPTH - 1);
   localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT - 1);

   typedef struct packed {
      logic [63:0] order;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
   } rec_t;

   rec_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [63:0]     order_ctr;
   logic [SW-1:0]   stall_cnt;

   // Per-channel record and rank among this cycle's valid channels.
   rec_t            rec  [NCH];
   logic [31:0]     rank [NCH];
   logic [31:0]     n_valid;
   logic            halt_hit;
   logic [31:0]     free_slots;
   logic            fits;
   logic            accept;
   logic            drop;
   logic            deq;
   rec_t            head;

   // Compaction: each valid lane gets rank = number of valid lanes below it,
   // which is both its order offset and its slot offset from wr_ptr.
   always_comb begin
      n_valid  = '0;
      halt_hit = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
         rank[ch]      = n_valid;
         rec[ch].order = order_ctr + 64'(n_valid);
         rec[ch].pc    = commit_pc[ch*32 +: 32];
         rec[ch].insn  = commit_insn[ch*32 +: 32];
         // x0 writes and non-writing instructions report an empty writeback.
         if (commit_regf_we[ch] && (commit_rd_addr[ch*5 +: 5] != 5'd0)) begin
            rec[ch].rd_addr  = commit_rd_addr[ch*5 +: 5];
            rec[ch].rd_wdata = commit_rd_wdata[ch*32 +: 32];
         end else begin
            rec[ch].rd_addr  = 5'd0;
            rec[ch].rd_wdata = 32'd0;
         end
         if (commit_valid[ch]) begin
            n_valid = n_valid + 32'd1;
            if (commit_pc_next[ch*32 +: 32] == commit_pc[ch*32 +: 32]) begin
               halt_hit = 1'b1;
            end
         end
      end
   end

   // Free space is taken before this cycle's dequeue, so a full FIFO drops
   // incoming commits even while its head is being drained.
   assign free_slots = 32'(DEPTH) - 32'(count);
   assign fits       = (n_valid <= free_slots);
   assign accept     = !rst && !halt && (n_valid != 32'd0) && fits;
   assign drop       = !halt && (n_valid != 32'd0) && !fits;
   assign deq        = trace_valid && trace_ready;

   // Storage has no reset; pointers and occupancy alone define its contents.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (commit_valid[ch]) begin
               mem[AW'((32'(wr_ptr) + rank[ch]) & PTR_MASK)] <= rec[ch];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         order_ctr    <= '0;
         commit_count <= '0;
         stall_cnt    <= '0;
         halt         <= 1'b0;
         timeout      <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr       <= AW'((32'(wr_ptr) + n_valid) & PTR_MASK);
            commit_count <= commit_count + 64'(n_valid);
         end
         if (deq) begin
            rd_ptr <= AW'((32'(rd_ptr) + 32'd1) & PTR_MASK);
         end
         count <= CW'(32'(count) + (accept ? n_valid : 32'd0) - (deq ? 32'd1 : 32'd0));

         // Orders are consumed by every pre-halt commit, dropped ones included,
         // so a gap in the trace marks exactly how many records were lost.
         if (!halt) begin
            order_ctr <= order_ctr + 64'(n_valid);
         end
         if (accept && halt_hit) begin
            halt <= 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end

         // Stall watchdog freezes once the core has halted.
         if (!halt) begin
            if (commit_valid != '0) begin
               stall_cnt <= '0;
            end else if (stall_cnt == STALL_LIMIT) begin
               timeout <= 1'b1;
            end else begin
               stall_cnt <= stall_cnt + SW'(1);
            end
         end
      end
   end

   assign trace_valid    = (count != '0);
   assign head           = mem[rd_ptr];
   assign trace_order    = trace_valid ? head.order    : 64'd0;
   assign trace_pc       = trace_valid ? head.pc       : 32'd0;
   assign trace_insn     = trace_valid ? head.insn     : 32'd0;
   assign trace_rd_addr  = trace_valid ? head.rd_addr  : 5'd0;
   assign trace_rd_wdata = trace_valid ? head.rd_wdata : 32'd0;

`ifdef COMMIT_MON_RW_CHECK_EN
   // Checked regardless of halt: bus misbehaviour is worth seeing after halt too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rw_conflict <= 1'b0;
      end else if (mem_read && mem_write) begin
         rw_conflict <= 1'b1;
      end
   end
`else
   logic unused_mem_strobes;
   assign unused_mem_strobes = mem_read ^ mem_write;
   assign rw_conflict        = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb_commit_trace_monitor: scenario tasks for commit_trace_monitor with a record
//    scoreboard; expected records are queued as commits are driven and checked
//    as they leave the trace port.
module tb_commit_trace_monitor;
   localparam int NCH     = 2;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
`ifdef COMMIT_MON_RW_CHECK_EN
   localparam logic RW_EXP = 1'b1;
`else
   localparam logic RW_EXP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NCH-1:0]    commit_valid = '0;
   logic [NCH*32-1:0] commit_pc = '0;
   logic [NCH*32-1:0] commit_pc_next = '0;
   logic [NCH*32-1:0] commit_insn = '0;
   logic [NCH-1:0]    commit_regf_we = '0;
   logic [NCH*5-1:0]  commit_rd_addr = '0;
   logic [NCH*32-1:0] commit_rd_wdata = '0;
   logic              mem_read = 1'b0;
   logic              mem_write = 1'b0;
   logic              trace_valid;
   logic              trace_ready = 1'b0;
   logic [63:0]       trace_order;
   logic [31:0]       trace_pc;
   logic [31:0]       trace_insn;
   logic [4:0]        trace_rd_addr;
   logic [31:0]       trace_rd_wdata;
   logic              halt;
   logic              timeout;
   logic              overflow;
   logic              rw_conflict;
   logic [63:0]       commit_count;

   typedef struct packed {
      logic [63:0] order;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd;
      logic [31:0] wd;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   commit_trace_monitor #(.NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .rst             (rst),
      .commit_valid    (commit_valid),
      .commit_pc       (commit_pc),
      .commit_pc_next  (commit_pc_next),
      .commit_insn     (commit_insn),
      .commit_regf_we  (commit_regf_we),
      .commit_rd_addr  (commit_rd_addr),
      .commit_rd_wdata (commit_rd_wdata),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .trace_valid     (trace_valid),
      .trace_ready     (trace_ready),
      .trace_order     (trace_order),
      .trace_pc        (trace_pc),
      .trace_insn      (trace_insn),
      .trace_rd_addr   (trace_rd_addr),
      .trace_rd_wdata  (trace_rd_wdata),
      .halt            (halt),
      .timeout         (timeout),
      .overflow        (overflow),
      .rw_conflict     (rw_conflict),
      .commit_count    (commit_count)
   );

   task automatic set_ch(input int ch, input logic [31:0] pc, input logic [31:0] pc_next,
                         input logic [31:0] insn, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd);
      commit_pc[ch*32 +: 32]       = pc;
      commit_pc_next[ch*32 +: 32]  = pc_next;
      commit_insn[ch*32 +: 32]     = insn;
      commit_regf_we[ch]           = we;
      commit_rd_addr[ch*5 +: 5]    = rd;
      commit_rd_wdata[ch*32 +: 32] = wd;
   endtask

   task automatic push_exp(input logic [63:0] order, input logic [31:0] pc,
                           input logic [31:0] insn, input logic [4:0] rd, input logic [31:0] wd);
      exp_t e;
      e.order = order; e.pc = pc; e.insn = insn; e.rd = rd; e.wd = wd;
      exp_q.push_back(e);
   endtask

   // One clock: the head is scored on the falling edge when it is being taken,
   // then control returns 1 time unit after the rising edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (trace_valid && trace_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL trace_unexpected got order=%0d pc=%h required none", trace_order, trace_pc);
         end else begin
            e = exp_q.pop_front();
            if ({trace_order, trace_pc, trace_insn, trace_rd_addr, trace_rd_wdata} !==
                {e.order, e.pc, e.insn, e.rd, e.wd}) begin
               bad++;
               $display("FAIL trace_record got order=%0d pc=%h insn=%h rd=%0d wd=%h required order=%0d pc=%h insn=%h rd=%0d wd=%h",
                        trace_order, trace_pc, trace_insn, trace_rd_addr, trace_rd_wdata,
                        e.order, e.pc, e.insn, e.rd, e.wd);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles);
      commit_valid = '0;
      trace_ready  = 1'b1;
      for (int i = 0; i < max_cycles && trace_valid; i++) step();
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      commit_valid = '0;
      trace_ready  = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (trace_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid got=%b required=0", trace_valid); end
      total++; if (trace_order !== 64'd0)  begin bad++; $display("FAIL rst_order got=%0d required=0", trace_order); end
      total++; if (trace_pc !== 32'd0)     begin bad++; $display("FAIL rst_pc got=%h required=0", trace_pc); end
      total++; if (commit_count !== 64'd0) begin bad++; $display("FAIL rst_count got=%0d required=0", commit_count); end
      total++; if ({halt, timeout, overflow, rw_conflict} !== 4'b0000)
         begin bad++; $display("FAIL rst_flags got=%b required=0000", {halt, timeout, overflow, rw_conflict}); end
   endtask

   task automatic test_dual_commit();
      do_reset();
      trace_ready = 1'b1;
      set_ch(0, 32'h6000_0000, 32'h6000_0004, 32'h0010_0093, 1'b1, 5'd1, 32'h0000_0005);
      set_ch(1, 32'h6000_0004, 32'h6000_0008, 32'h0020_0113, 1'b1, 5'd2, 32'h0000_0006);
      commit_valid = 2'b11;
      push_exp(64'd0, 32'h6000_0000, 32'h0010_0093, 5'd1, 32'h0000_0005);
      push_exp(64'd1, 32'h6000_0004, 32'h0020_0113, 5'd2, 32'h0000_0006);
      step();
      total++; if (trace_valid !== 1'b1) begin bad++; $display("FAIL dual_latency got=%b required=1", trace_valid); end
      drain(8);
      total++; if (commit_count !== 64'd2) begin bad++; $display("FAIL dual_count got=%0d required=2", commit_count); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL dual_drained got=%0d left required=0", exp_q.size()); end
   endtask

   task automatic test_compaction();
      do_reset();
      trace_ready = 1'b1;
      set_ch(1, 32'h0000_0100, 32'h0000_0104, 32'h0000_0013, 1'b1, 5'd0, 32'h0000_dead);
      commit_valid = 2'b10;
      push_exp(64'd0, 32'h0000_0100, 32'h0000_0013, 5'd0, 32'd0);
      step();
      set_ch(0, 32'h0000_0200, 32'h0000_0204, 32'h0050_0293, 1'b1, 5'd5, 32'h0000_1234);
      commit_valid = 2'b01;
      push_exp(64'd1, 32'h0000_0200, 32'h0050_0293, 5'd5, 32'h0000_1234);
      step();
      set_ch(0, 32'h0000_0300, 32'h0000_0304, 32'h0070_0393, 1'b0, 5'd7, 32'h0000_0055);
      set_ch(1, 32'h0000_0304, 32'h0000_0308, 32'h0030_0193, 1'b1, 5'd3, 32'h0000_0077);
      commit_valid = 2'b11;
      push_exp(64'd2, 32'h0000_0300, 32'h0070_0393, 5'd0, 32'd0);
      push_exp(64'd3, 32'h0000_0304, 32'h0030_0193, 5'd3, 32'h0000_0077);
      step();
      drain(8);
      total++; if (commit_count !== 64'd4) begin bad++; $display("FAIL compact_count got=%0d required=4", commit_count); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL compact_drained got=%0d left required=0", exp_q.size()); end
   endtask

   task automatic test_overflow();
      do_reset();
      trace_ready = 1'b0;
      set_ch(0, 32'h6000_0000, 32'h6000_0004, 32'h1111_1111, 1'b1, 5'd1, 32'h0000_00a0);
      set_ch(1, 32'h6000_0004, 32'h6000_0008, 32'h2222_2222, 1'b1, 5'd2, 32'h0000_00b0);
      commit_valid = 2'b11;
      for (int c = 0; c < 2; c++) begin
         push_exp(64'(2*c),   32'h6000_0000, 32'h1111_1111, 5'd1, 32'h0000_00a0);
         push_exp(64'(2*c+1), 32'h6000_0004, 32'h2222_2222, 5'd2, 32'h0000_00b0);
         step();
      end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b required=0", overflow); end
      step();  // orders 4,5 dropped
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b required=1", overflow); end
      total++; if (commit_count !== 64'd4) begin bad++; $display("FAIL ovf_count got=%0d required=4", commit_count); end
      drain(8);
      commit_valid = 2'b01;
      push_exp(64'd6, 32'h6000_0000, 32'h1111_1111, 5'd1, 32'h0000_00a0);
      step();
      drain(8);
      // Full FIFO with a same-cycle dequeue still drops the incoming commit.
      trace_ready  = 1'b0;
      commit_valid = 2'b11;
      for (int c = 0; c < 2; c++) begin
         push_exp(64'(7 + 2*c), 32'h6000_0000, 32'h1111_1111, 5'd1, 32'h0000_00a0);
         push_exp(64'(8 + 2*c), 32'h6000_0004, 32'h2222_2222, 5'd2, 32'h0000_00b0);
         step();
      end
      trace_ready  = 1'b1;
      commit_valid = 2'b01;
      step();  // order 11 dropped
      push_exp(64'd12, 32'h6000_0000, 32'h1111_1111, 5'd1, 32'h0000_00a0);
      step();
      drain(8);
      total++; if (commit_count !== 64'd10) begin bad++; $display("FAIL ovf_final_count got=%0d required=10", commit_count); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_drained got=%0d left required=0", exp_q.size()); end
   endtask

   task automatic test_halt();
      do_reset();
      trace_ready = 1'b1;
      set_ch(0, 32'h6000_0000, 32'h6000_0004, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
      commit_valid = 2'b01;
      push_exp(64'd0, 32'h6000_0000, 32'h0000_0013, 5'd0, 32'd0);
      step();
      set_ch(0, 32'h6000_0004, 32'h6000_0008, 32'h0010_0093, 1'b1, 5'd1, 32'h0000_0009);
      set_ch(1, 32'h6000_0100, 32'h6000_0100, 32'h0000_006f, 1'b0, 5'd0, 32'd0);
      commit_valid = 2'b11;
      push_exp(64'd1, 32'h6000_0004, 32'h0010_0093, 5'd1, 32'h0000_0009);
      push_exp(64'd2, 32'h6000_0100, 32'h0000_006f, 5'd0, 32'd0);
      step();
      total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_set got=%b required=1", halt); end
      set_ch(0, 32'h6000_0200, 32'h6000_0204, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
      set_ch(1, 32'h6000_0204, 32'h6000_0208, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
      commit_valid = 2'b11;
      step();
      step();
      commit_valid = '0;
      for (int i = 0; i < 12; i++) step();
      total++; if (commit_count !== 64'd3) begin bad++; $display("FAIL halt_count got=%0d required=3", commit_count); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL halt_stall_hold got=%b required=0", timeout); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL halt_drained got=%0d left required=0", exp_q.size()); end
      total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL halt_empty got=%b required=0", trace_valid); end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < 7; i++) step();
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_edge7 got=%b required=0", timeout); end
      step();
      total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_edge8 got=%b required=1", timeout); end
      do_reset();
      trace_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      set_ch(0, 32'h0000_0400, 32'h0000_0404, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
      commit_valid = 2'b01;
      push_exp(64'd0, 32'h0000_0400, 32'h0000_0013, 5'd0, 32'd0);
      step();
      commit_valid = '0;
      for (int i = 0; i < 7; i++) step();
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_restart7 got=%b required=0", timeout); end
      step();
      total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_restart8 got=%b required=1", timeout); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL tmo_drained got=%0d left required=0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      trace_ready = 1'b0;
      set_ch(0, 32'h0000_0500, 32'h0000_0504, 32'haaaa_aaaa, 1'b1, 5'd4, 32'h0000_0044);
      set_ch(1, 32'h0000_0504, 32'h0000_0508, 32'hbbbb_bbbb, 1'b1, 5'd6, 32'h0000_0066);
      commit_valid = 2'b11;
      step();
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b required=0", trace_valid); end
      total++; if (trace_order !== 64'd0 || trace_pc !== 32'd0) begin bad++; $display("FAIL arst_data got order=%0d pc=%h required 0", trace_order, trace_pc); end
      total++; if (commit_count !== 64'd0) begin bad++; $display("FAIL arst_count got=%0d required=0", commit_count); end
      step();  // commit presented on an edge with rst asserted
      rst          = 1'b0;
      commit_valid = '0;
      #1;
      total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL rst_edge_accept got=%b required=0", trace_valid); end
      commit_valid = 2'b01;
      trace_ready  = 1'b1;
      push_exp(64'd0, 32'h0000_0500, 32'haaaa_aaaa, 5'd4, 32'h0000_0044);
      step();
      drain(8);
      total++; if (commit_count !== 64'd1) begin bad++; $display("FAIL post_rst_count got=%0d required=1", commit_count); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL post_rst_drained got=%0d left required=0", exp_q.size()); end
   endtask

   task automatic test_rw_conflict();
      do_reset();
      mem_read = 1'b1;
      step();
      total++; if (rw_conflict !== 1'b0) begin bad++; $display("FAIL rw_read_only got=%b required=0", rw_conflict); end
      mem_write = 1'b1;
      step();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      total++; if (rw_conflict !== RW_EXP) begin bad++; $display("FAIL rw_set got=%b required=%b", rw_conflict, RW_EXP); end
      step();
      step();
      total++; if (rw_conflict !== RW_EXP) begin bad++; $display("FAIL rw_sticky got=%b required=%b", rw_conflict, RW_EXP); end
      do_reset();
      total++; if (rw_conflict !== 1'b0) begin bad++; $display("FAIL rw_cleared got=%b required=0", rw_conflict); end
   endtask

   initial begin
      test_reset();
      test_dual_commit();
      test_compaction();
      test_overflow();
      test_halt();
      test_timeout();
      test_reset_mid_drain();
      test_rw_conflict();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
